coin_change_gen: RTL

Parametrised change dispenser. Accepts an amount over a valid/ready input handshake and decomposes it greedily into a configurable set of coin denominations, one coin per two cycles. It tracks a finite per-denomination coin stock with refill and rolls back on insufficient change. It sits between the payment front-end and the coin-ejector driver, and presents its result over a valid/ready output handshake.

---
 rtl/coin_pkg.sv | 19 +
 rtl/coin_select.sv | 33 +++
 rtl/coin_change_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin change dispenser.
package coin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_GIVE,
    ST_FAIL,
    ST_DONE
  } coin_state_t;

  // Index 0 holds the largest coin: {25,10,5,1} packed with 8-bit entries.
  localparam logic [31:0] DEF_DENOM_VAL = {8'd1, 8'd5, 8'd10, 8'd25};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational picker: lowest index whose coin fits the remainder and is in stock.
module coin_select
  import coin_pkg::*;
#(
  parameter int AMT_W     = 8,
  parameter int NUM_DENOM = 4,
  parameter int STK_W     = 4,
  localparam int IDX_W    = idx_w(NUM_DENOM)
) (
  input  logic [AMT_W-1:0]           rem,
  input  logic [NUM_DENOM*STK_W-1:0] stock,
  input  logic [NUM_DENOM*AMT_W-1:0] denom_val,
  output logic                       found,
  output logic [IDX_W-1:0]           idx
);

  logic [NUM_DENOM-1:0] elig;

  for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_elig
    assign elig[gi] = (denom_val[gi*AMT_W +: AMT_W] <= rem) &&
                      (stock[gi*STK_W +: STK_W] != '0);
  end

  // Scan high to low so the lowest eligible index is the last one written.
  always_comb begin
    found = |elig;
    idx   = '0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (elig[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/coin_change_gen.sv
// Greedy change dispenser with finite per-denomination stock, refill and rollback.
module coin_change_gen
  import coin_pkg::*;
#(
  parameter int AMT_W                          = 8,
  parameter int NUM_DENOM                      = 4,
  parameter logic [NUM_DENOM*AMT_W-1:0] DENOM_VAL = DEF_DENOM_VAL,
  parameter int STK_W                          = 4,
  parameter int INIT_STOCK                     = 4,
  localparam int IDX_W                         = idx_w(NUM_DENOM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AMT_W-1:0]           in_amount,
  input  logic                       refill_valid,
  output logic                       refill_ready,
  input  logic [IDX_W-1:0]           refill_idx,
  input  logic [STK_W-1:0]           refill_cnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DENOM*AMT_W-1:0] out_counts,
  output logic                       out_error,
  output logic [NUM_DENOM*STK_W-1:0] stock
);

  coin_state_t state_reg, state_next;

  logic [AMT_W-1:0]           rem_reg;
  logic [IDX_W-1:0]           sel_reg;
  logic                       err_reg;
  logic [NUM_DENOM*AMT_W-1:0] counts_vec;
  logic [NUM_DENOM*STK_W-1:0] stock_vec;
  logic                       sel_found;
  logic [IDX_W-1:0]           sel_idx;
  logic [AMT_W-1:0]           sel_val;
  logic                       accept;
  logic                       refill_fire;

  coin_select #(
    .AMT_W    (AMT_W),
    .NUM_DENOM(NUM_DENOM),
    .STK_W    (STK_W)
  ) u_select (
    .rem      (rem_reg),
    .stock    (stock_vec),
    .denom_val(DENOM_VAL),
    .found    (sel_found),
    .idx      (sel_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_valid) state_next = ST_CHECK;
      ST_CHECK: begin
        if (rem_reg == '0)  state_next = ST_DONE;
        else if (sel_found) state_next = ST_GIVE;
        else                state_next = ST_FAIL;
      end
      ST_GIVE:  state_next = ST_CHECK;
      ST_FAIL:  state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_reg == ST_IDLE);
    refill_ready = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    out_valid    = (state_reg == ST_DONE);
  end

  assign accept      = (state_reg == ST_IDLE) && in_valid;
  assign refill_fire = refill_valid && refill_ready;
  assign out_counts  = counts_vec;
  assign out_error   = err_reg;
  assign stock       = stock_vec;

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (sel_reg == IDX_W'(i)) sel_val = DENOM_VAL[i*AMT_W +: AMT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg <= '0;
      sel_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (in_valid) begin
          rem_reg <= in_amount;
          err_reg <= 1'b0;
        end
        ST_CHECK: if (sel_found) sel_reg <= sel_idx;
        ST_GIVE:  rem_reg <= rem_reg - sel_val;
        ST_FAIL:  err_reg <= 1'b1;
        default:  ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_denom
    logic [AMT_W-1:0] cnt_reg;
    logic [STK_W-1:0] stk_reg;
    logic [STK_W:0]   refill_sum;
    logic             give_hit;
    logic             refill_hit;

    assign give_hit   = (state_reg == ST_GIVE) && (sel_reg == IDX_W'(gi));
    // An index beyond NUM_DENOM-1 matches no slot and is silently dropped.
    assign refill_hit = refill_fire && (refill_idx == IDX_W'(gi));
    assign refill_sum = {1'b0, stk_reg} + {1'b0, refill_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      cnt_reg <= '0;
      else if (accept)                 cnt_reg <= '0;
      else if (give_hit)               cnt_reg <= cnt_reg + 1'b1;
      else if (state_reg == ST_FAIL)   cnt_reg <= '0;
    end

    // Coins given in this request came out of this counter, so rollback fits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      stk_reg <= STK_W'(INIT_STOCK);
      else if (give_hit)               stk_reg <= stk_reg - 1'b1;
      else if (state_reg == ST_FAIL)   stk_reg <= stk_reg + STK_W'(cnt_reg);
      else if (refill_hit)             stk_reg <= refill_sum[STK_W] ? '1 : refill_sum[STK_W-1:0];
    end

    assign counts_vec[gi*AMT_W +: AMT_W] = cnt_reg;
    assign stock_vec[gi*STK_W +: STK_W]  = stk_reg;
  end

endmodule
